// File: rtl/gcd_scheduler.sv
// gcd_scheduler: round-robin job arbiter and sequencer for a shared 16-bit
// subtractive GCD datapath. Accepts jobs over per-requester valid/ready,
// loads A and B, runs one subtraction per cycle until A==B, and returns the
// result tagged with the requester index. Zero operands bypass the datapath
// and an iteration ceiling aborts jobs that would run too long.
module gcd_scheduler #(
    parameter int N_REQ    = 4,
    parameter int ID_W     = 2,      // 2**ID_W must cover N_REQ
    parameter int WIDTH    = 16,
    parameter int MAX_ITER = 65535
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH-1:0]       res_data,
    output logic [ID_W-1:0]        res_id,
    output logic                   res_err,
    output logic                   busy,
    output logic [WIDTH-1:0]       dp_data_in,
    output logic                   dp_loadA,
    output logic                   dp_loadB,
    output logic                   dp_sel1,
    output logic                   dp_sel2,
    output logic                   dp_sel_in,
    input  logic                   dp_G,
    input  logic                   dp_E,
    input  logic                   dp_L,
    input  logic [WIDTH-1:0]       dp_a
);

    localparam int          CNT_W = $clog2(MAX_ITER + 1);
    localparam int unsigned N_U   = N_REQ;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        ITER,
        DONE
    } state_t;

    state_t            state, state_next;
    logic [WIDTH-1:0]  op_a, op_b;
    logic              zero_job;
    logic [CNT_W-1:0]  iter_cnt;
    logic [ID_W-1:0]   last_id;

    logic              grant_valid;
    logic [ID_W-1:0]   grant_id;
    logic [WIDTH-1:0]  grant_a, grant_b;
    logic              grant_zero;
    int                idx;

    logic              take_job, fin_zero, fin_match, fin_abort, step;

    // Round-robin search starting one past the last granted requester
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        grant_a     = '0;
        grant_b     = '0;
        idx         = 0;
        for (int unsigned i = 0; i < N_U; i++) begin
            idx = (int'(last_id) + 1 + int'(i)) % N_REQ;
            if (!grant_valid && req_valid[idx]) begin
                grant_valid = 1'b1;
                grant_id    = ID_W'(idx);
                grant_a     = req_a[idx*WIDTH +: WIDTH];
                grant_b     = req_b[idx*WIDTH +: WIDTH];
            end
        end
        grant_zero = (grant_a == '0) || (grant_b == '0);
    end

    // Next-state and datapath control decode
    always_comb begin
        state_next = state;
        dp_data_in = '0;
        dp_loadA   = 1'b0;
        dp_loadB   = 1'b0;
        dp_sel1    = 1'b0;
        dp_sel2    = 1'b0;
        dp_sel_in  = 1'b0;
        take_job   = 1'b0;
        fin_zero   = 1'b0;
        fin_match  = 1'b0;
        fin_abort  = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    take_job = 1'b1;
                    // Zero-operand jobs spend one cycle in ITER without
                    // touching the datapath so their result lands at edge 1.
                    state_next = grant_zero ? ITER : LOAD_A;
                end
            end
            LOAD_A: begin
                dp_sel_in  = 1'b1;
                dp_data_in = op_a;
                dp_loadA   = 1'b1;
                state_next = LOAD_B;
            end
            LOAD_B: begin
                dp_sel_in  = 1'b1;
                dp_data_in = op_b;
                dp_loadB   = 1'b1;
                state_next = ITER;
            end
            ITER: begin
                if (zero_job) begin
                    fin_zero   = 1'b1;
                    state_next = DONE;
                end else if (dp_E) begin
                    fin_match  = 1'b1;
                    state_next = DONE;
                end else if (iter_cnt == CNT_W'(MAX_ITER)) begin
                    fin_abort  = 1'b1;
                    state_next = DONE;
                end else if (dp_G) begin
                    dp_sel2  = 1'b1;
                    dp_loadA = 1'b1;
                    step     = 1'b1;
                end else if (dp_L) begin
                    dp_sel1  = 1'b1;
                    dp_loadB = 1'b1;
                    step     = 1'b1;
                end
            end
            DONE: begin
                if (res_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // One-hot accept strobe; held low while reset is asserted
    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < N_U; i++) begin
            req_ready[i] = take_job && !rst && (grant_id == ID_W'(i));
        end
    end

    // Status outputs derived directly from the state register
    always_comb begin
        res_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Job capture, iteration counter and registered result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            zero_job <= 1'b0;
            iter_cnt <= '0;
            last_id  <= ID_W'(N_REQ - 1);
            res_data <= '0;
            res_id   <= '0;
            res_err  <= 1'b0;
        end else begin
            if (take_job) begin
                op_a     <= grant_a;
                op_b     <= grant_b;
                zero_job <= grant_zero;
                iter_cnt <= '0;
                last_id  <= grant_id;
                res_id   <= grant_id;
            end
            if (step) iter_cnt <= iter_cnt + CNT_W'(1);
            if (fin_zero) begin
                res_data <= op_a | op_b;
                res_err  <= 1'b0;
            end
            if (fin_match) begin
                res_data <= dp_a;
                res_err  <= 1'b0;
            end
            if (fin_abort) begin
                res_data <= '0;
                res_err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gcd_scheduler.sv
// tb_gcd_scheduler: drives two scheduler instances (default iteration
// ceiling and a ceiling of 16), each wired to a behavioural GCD datapath,
// and compares every result against a plain-arithmetic reference.
module tb_gcd_scheduler;

    localparam int N = 4;
    localparam int W = 16;

    logic clk, rst;

    int checks = 0;
    int errors = 0;

    // main instance
    logic [N-1:0]   req_valid, req_ready;
    logic [N*W-1:0] req_a, req_b;
    logic           res_valid, res_ready, res_err, busy;
    logic [W-1:0]   res_data, dp_data_in, dp_a;
    logic [1:0]     res_id;
    logic           dp_loadA, dp_loadB, dp_sel1, dp_sel2, dp_sel_in;
    logic           dp_G, dp_E, dp_L;
    logic [W-1:0]   ra, rb, op1, op2, mux_in;

    // instance with MAX_ITER=16
    logic [N-1:0]   v16, rdy16;
    logic [N*W-1:0] a16, b16;
    logic           rv16, rr16, rerr16, busy16;
    logic [W-1:0]   rd16, din16, pa16;
    logic [1:0]     rid16;
    logic           la16, lb16, s1_16, s2_16, sin16, g16, e16, l16;
    logic [W-1:0]   ra16, rb16, op1_16, op2_16, mux16;

    int model_last;
    logic [W-1:0] ja [N];
    logic [W-1:0] jb [N];

    gcd_scheduler #(.N_REQ(N), .ID_W(2), .WIDTH(W), .MAX_ITER(65535)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .res_err(res_err),
        .busy(busy), .dp_data_in(dp_data_in),
        .dp_loadA(dp_loadA), .dp_loadB(dp_loadB),
        .dp_sel1(dp_sel1), .dp_sel2(dp_sel2), .dp_sel_in(dp_sel_in),
        .dp_G(dp_G), .dp_E(dp_E), .dp_L(dp_L), .dp_a(dp_a)
    );

    gcd_scheduler #(.N_REQ(N), .ID_W(2), .WIDTH(W), .MAX_ITER(16)) dut16 (
        .clk(clk), .rst(rst),
        .req_valid(v16), .req_ready(rdy16),
        .req_a(a16), .req_b(b16),
        .res_valid(rv16), .res_ready(rr16),
        .res_data(rd16), .res_id(rid16), .res_err(rerr16),
        .busy(busy16), .dp_data_in(din16),
        .dp_loadA(la16), .dp_loadB(lb16),
        .dp_sel1(s1_16), .dp_sel2(s2_16), .dp_sel_in(sin16),
        .dp_G(g16), .dp_E(e16), .dp_L(l16), .dp_a(pa16)
    );

    // behavioural datapaths
    always_comb begin
        op1    = dp_sel1 ? rb : ra;
        op2    = dp_sel2 ? rb : ra;
        mux_in = dp_sel_in ? dp_data_in : op1 - op2;
        dp_G   = ra > rb;
        dp_E   = ra == rb;
        dp_L   = ra < rb;
        dp_a   = ra;
        op1_16 = s1_16 ? rb16 : ra16;
        op2_16 = s2_16 ? rb16 : ra16;
        mux16  = sin16 ? din16 : op1_16 - op2_16;
        g16    = ra16 > rb16;
        e16    = ra16 == rb16;
        l16    = ra16 < rb16;
        pa16   = ra16;
    end

    always @(posedge clk) begin
        if (dp_loadA) ra <= mux_in;
        if (dp_loadB) rb <= mux_in;
        if (la16) ra16 <= mux16;
        if (lb16) rb16 <= mux16;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: GCD by Euclid, subtraction count by repeated subtraction,
    // latency from the edge-numbering rules.
    task automatic ref_job(input logic [W-1:0] a, input logic [W-1:0] b, input int maxit,
                           output logic [W-1:0] data, output logic err, output int lat);
        int x, y, t, k;
        if (a == 0 || b == 0) begin
            data = a | b; err = 1'b0; lat = 1;
        end else begin
            x = a; y = b; k = 0;
            while (x != y && k <= maxit) begin
                if (x > y) x = x - y; else y = y - x;
                k++;
            end
            if (k > maxit) begin
                data = '0; err = 1'b1; lat = 3 + maxit;
            end else begin
                x = a; y = b;
                while (y != 0) begin t = x % y; x = y; y = t; end
                data = W'(x); err = 1'b0; lat = 3 + k;
            end
        end
    endtask

    task automatic raise(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        ja[id] = a; jb[id] = b;
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_valid[id] = 1'b1;
    endtask

    // Waits for the grant, checks it against the round-robin model, and
    // returns just after the accepting edge (edge 0).
    task automatic accept_next(output int gid);
        int exp_id, waited, c;
        exp_id = -1;
        for (int i = 1; i <= N; i++) begin
            c = (model_last + i) % N;
            if (exp_id < 0 && req_valid[c]) exp_id = c;
        end
        gid = -1; waited = 0;
        while (gid < 0 && waited < 50) begin
            #1;
            for (int i = 0; i < N; i++) if (req_ready[i]) gid = i;
            if (gid < 0) begin @(posedge clk); #1; waited++; end
        end
        chk("grant_id", 64'(gid), 64'(exp_id));
        if (gid < 0) begin
            req_valid = '0;
            return;
        end
        chk("ready_onehot", 64'($countones(req_ready)), 64'd1);
        @(posedge clk); #1;
        req_valid[gid] = 1'b0;
        model_last = gid;
    endtask

    // Counts edges until res_valid, recording which edges carried loads.
    task automatic wait_result(output int lat, output logic [31:0] la, output logic [31:0] lb,
                               output logic both);
        int n;
        n = 0; la = '0; lb = '0; both = 1'b0;
        while (!res_valid && n < 70000) begin
            if (n < 31) begin
                if (dp_loadA) la[n+1] = 1'b1;
                if (dp_loadB) lb[n+1] = 1'b1;
            end
            if (dp_loadA && dp_loadB) both = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        lat = n;
    endtask

    task automatic check_job(input int g, output logic [31:0] la, output logic [31:0] lb);
        int lat, elat;
        logic both, eerr;
        logic [W-1:0] edata;
        wait_result(lat, la, lb, both);
        ref_job(ja[g], jb[g], 65535, edata, eerr, elat);
        chk("latency", 64'(lat), 64'(elat));
        chk("res_data", 64'(res_data), 64'(edata));
        chk("res_id", 64'(res_id), 64'(g));
        chk("res_err", 64'(res_err), 64'(eerr));
        chk("loads_exclusive", 64'(both), 64'd0);
        if (res_ready) begin
            @(posedge clk); #1;
            chk("res_consumed", 64'(res_valid), 64'd0);
        end
    endtask

    task automatic serve_all();
        int g;
        logic [31:0] la, lb;
        while (req_valid != '0) begin
            accept_next(g);
            if (g < 0) break;
            check_job(g, la, lb);
        end
    endtask

    function automatic logic [63:0] outs_main();
        return {18'd0, res_valid, busy, req_ready, res_data, res_id, res_err,
                dp_data_in, dp_loadA, dp_loadB, dp_sel1, dp_sel2, dp_sel_in};
    endfunction

    initial begin
        int g, n, subs, elat;
        logic [31:0] la, lb;
        logic [W-1:0] edata;
        logic eerr;
        logic [3:0] mask;

        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b1;
        v16 = '0; a16 = '0; b16 = '0; rr16 = 1'b1;
        model_last = N - 1;
        #12;
        chk("reset_outputs", outs_main(), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // single job (12,8) with load-edge pattern
        raise(0, 16'd12, 16'd8);
        accept_next(g);
        check_job(0, la, lb);
        chk("loadA_edges", 64'(la), 64'h0a);
        chk("loadB_edges", 64'(lb), 64'h14);

        // all four at once, then 1 alone, then 0 and 1 together
        raise(0, 16'd30, 16'd18); raise(1, 16'd49, 16'd35);
        raise(2, 16'd17, 16'd5);  raise(3, 16'd64, 16'd40);
        serve_all();
        raise(1, 16'd9, 16'd6);
        serve_all();
        raise(0, 16'd10, 16'd4); raise(1, 16'd27, 16'd18);
        serve_all();

        // zero-operand bypass and equal operands
        raise(2, 16'd0, 16'd9);
        accept_next(g);
        check_job(2, la, lb);
        chk("bypass_no_loads", 64'(la | lb), 64'd0);
        raise(3, 16'd0, 16'd0);
        serve_all();
        raise(0, 16'd7, 16'd7);
        serve_all();

        // backpressure in DONE while another requester waits
        res_ready = 1'b0;
        raise(1, 16'd15, 16'd10);
        accept_next(g);
        begin
            logic both;
            wait_result(n, la, lb, both);
        end
        ref_job(16'd15, 16'd10, 65535, edata, eerr, elat);
        chk("bp_latency", 64'(n), 64'(elat));
        raise(2, 16'd40, 16'd24);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 64'(res_valid), 64'd1);
            chk("bp_data", 64'(res_data), 64'(edata));
            chk("bp_id", 64'(res_id), 64'd1);
            chk("bp_ready", 64'(req_ready), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", 64'(res_valid), 64'd0);
        serve_all();

        // iteration ceiling of 16 on the second instance
        a16[15:0] = 16'hffff; b16[15:0] = 16'd1; v16 = 4'b0001;
        n = 0;
        while (!rdy16[0] && n < 50) begin @(posedge clk); #1; n++; end
        chk("abort_accept", 64'(rdy16[0]), 64'd1);
        @(posedge clk); #1;
        v16 = '0;
        n = 0; subs = 0;
        while (!rv16 && n < 200) begin
            if (la16 && !sin16) subs++;
            @(posedge clk); #1;
            n++;
        end
        ref_job(16'hffff, 16'd1, 16, edata, eerr, elat);
        chk("abort_latency", 64'(n), 64'(elat));
        chk("abort_data", 64'(rd16), 64'(edata));
        chk("abort_err", 64'(rerr16), 64'(eerr));
        chk("abort_subs", 64'(subs), 64'd16);
        @(posedge clk); #1;
        chk("abort_consumed", 64'(rv16), 64'd0);

        // randomized batches against the reference
        for (int r = 0; r < 8; r++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                if (mask[i]) begin
                    raise(i, ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 255)),
                             ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 255)));
                end
            end
            serve_all();
        end

        // longest legal job at the default ceiling
        raise(2, 16'hffff, 16'd1);
        serve_all();

        // asynchronous reset mid-ITER
        raise(0, 16'd100, 16'd3);
        accept_next(g);
        repeat (5) begin @(posedge clk); #1; end
        chk("pre_reset_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_outputs", outs_main(), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_last = N - 1;
        raise(3, 16'd21, 16'd14);
        raise(0, 16'd9, 16'd6);
        serve_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
